// File: rtl/memory_access.sv
// MEM stage: data-memory load/store over a req/ack handshake, load formatting,
// writeback selection into MEM/WB, Galois LFSR source and a one-cycle peripheral write port.
module memory_access #(
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc_mem,
    input  logic [31:0] write_data_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [1:0]  wb_sel_mem,
    input  logic [1:0]  read_width_mem,
    input  logic        wrt_dst_mem,
    input  logic        random_mem,
    input  logic        mem_wrt_en_mem,
    input  logic        reg_wrt_en_mem,
    input  logic        read_unsigned_mem,
    input  logic        rd_en_mem,
    output logic        stall_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        periph_we,
    output logic [31:0] periph_wdata,
    output logic [31:0] wb_data_wb,
    output logic        reg_wrt_en_wb,
    output logic        misalign_err_wb,
    output logic        timeout_err_wb
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [8:0]  TO_LIMIT  = 9'(ACK_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d, we_q, we_d, to_pend_q, to_pend_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] lfsr_q, lfsr_d, wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d, mis_q, mis_d, to_q, to_d;

    logic        is_store, is_load, periph_st, dmem_op, misalign;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_fmt, wb_mux;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // A store takes priority over a simultaneous load; peripheral stores bypass dmem.
    assign is_store  = mem_wrt_en_mem;
    assign is_load   = rd_en_mem & ~mem_wrt_en_mem;
    assign periph_st = is_store & wrt_dst_mem;
    assign dmem_op   = is_load | (is_store & ~wrt_dst_mem);
    assign misalign  = ((read_width_mem == 2'd1) & alu_result_mem[0]) |
                       (read_width_mem[1] & (alu_result_mem[1:0] != 2'b00));

    always_comb begin
        case (read_width_mem)
            2'd0:    begin be_c = 4'b0001 << alu_result_mem[1:0]; wdata_c = {4{write_data_mem[7:0]}}; end
            2'd1:    begin be_c = alu_result_mem[1] ? 4'b1100 : 4'b0011; wdata_c = {2{write_data_mem[15:0]}}; end
            default: begin be_c = 4'b1111; wdata_c = write_data_mem; end
        endcase
    end

    // EX/MEM is held during the access, so the address bits still select the lane in RESP.
    assign ld_byte = rdata_q[{alu_result_mem[1:0], 3'b000} +: 8];
    assign ld_half = alu_result_mem[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        case (read_width_mem)
            2'd0:    load_fmt = {{24{~read_unsigned_mem & ld_byte[7]}}, ld_byte};
            2'd1:    load_fmt = {{16{~read_unsigned_mem & ld_half[15]}}, ld_half};
            default: load_fmt = rdata_q;
        endcase
        case (wb_sel_mem)
            2'd0:    wb_mux = alu_result_mem;
            2'd1:    wb_mux = load_fmt;
            2'd2:    wb_mux = next_pc_mem;
            default: wb_mux = lfsr_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        to_pend_d = to_pend_q;
        wb_data_d = 32'h0;
        wb_we_d   = 1'b0;
        mis_d     = 1'b0;
        to_d      = 1'b0;
        stall_mem = 1'b0;
        periph_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_op && !misalign) begin
                    stall_mem = 1'b1;
                    state_d   = BUSY;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {alu_result_mem[31:2], 2'b00};
                    be_d      = be_c;
                    wdata_d   = is_store ? wdata_c : 32'h0;
                    cnt_d     = 8'd0;
                    to_pend_d = 1'b0;
                end else if (dmem_op) begin
                    mis_d = 1'b1;
                end else begin
                    periph_we = periph_st;
                    wb_data_d = wb_mux;
                    wb_we_d   = reg_wrt_en_mem & ~is_store;
                end
            end
            BUSY: begin
                stall_mem = 1'b1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    rdata_d = dmem_rdata;
                    state_d = RESP;
                end else if ({1'b0, cnt_q} + 9'd1 == TO_LIMIT) begin
                    req_d     = 1'b0;
                    to_pend_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                we_d    = 1'b0;
                addr_d  = 32'h0;
                be_d    = 4'h0;
                wdata_d = 32'h0;
                if (to_pend_q) begin
                    to_d = 1'b1;
                end else begin
                    wb_data_d = wb_mux;
                    wb_we_d   = reg_wrt_en_mem & ~is_store;
                end
            end
            default: state_d = IDLE;
        endcase
        lfsr_d = lfsr_q;
        if (random_mem && !stall_mem)
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            to_pend_q <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            wb_data_q <= 32'h0;
            wb_we_q   <= 1'b0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            to_pend_q <= to_pend_d;
            lfsr_q    <= lfsr_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
        end
    end

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_addr       = addr_q;
    assign dmem_be         = be_q;
    assign dmem_wdata      = wdata_q;
    assign periph_wdata    = periph_we ? write_data_mem : 32'h0;
    assign wb_data_wb      = wb_data_q;
    assign reg_wrt_en_wb   = wb_we_q;
    assign misalign_err_wb = mis_q;
    assign timeout_err_wb  = to_q;
endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: vector table for single-cycle ops, scripted multi-cycle
// accesses with an ack responder, and a queue of expected MEM/WB results.
module tb_memory_access;
    logic        clk, rst_n;
    logic [31:0] next_pc_mem, write_data_mem, alu_result_mem;
    logic [1:0]  wb_sel_mem, read_width_mem;
    logic        wrt_dst_mem, random_mem, mem_wrt_en_mem, reg_wrt_en_mem;
    logic        read_unsigned_mem, rd_en_mem;
    logic        stall_mem, dmem_req, dmem_we, dmem_ack, periph_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, periph_wdata, wb_data_wb;
    logic [3:0]  dmem_be;
    logic        reg_wrt_en_wb, misalign_err_wb, timeout_err_wb;
    logic        auto_ack, stray_ack;
    int          ack_cfg;
    int          n_cmp, n_err;

    assign dmem_ack = auto_ack | stray_ack;

    memory_access dut (
        .clk(clk), .rst_n(rst_n),
        .next_pc_mem(next_pc_mem), .write_data_mem(write_data_mem),
        .alu_result_mem(alu_result_mem), .wb_sel_mem(wb_sel_mem),
        .read_width_mem(read_width_mem), .wrt_dst_mem(wrt_dst_mem),
        .random_mem(random_mem), .mem_wrt_en_mem(mem_wrt_en_mem),
        .reg_wrt_en_mem(reg_wrt_en_mem), .read_unsigned_mem(read_unsigned_mem),
        .rd_en_mem(rd_en_mem), .stall_mem(stall_mem),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .periph_we(periph_we), .periph_wdata(periph_wdata),
        .wb_data_wb(wb_data_wb), .reg_wrt_en_wb(reg_wrt_en_wb),
        .misalign_err_wb(misalign_err_wb), .timeout_err_wb(timeout_err_wb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Ack responder: pulses ack in the (ack_cfg+1)-th cycle that dmem_req is high.
    initial begin
        int age;
        age = 0;
        auto_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (dmem_req) age++;
            else age = 0;
            auto_ack = (ack_cfg >= 0) && dmem_req && (age == ack_cfg + 1);
        end
    end

    typedef struct {
        logic [31:0] npc, wd, alu;
        logic [1:0]  wsel, width;
        logic        dst, rnd, mwe, rwe, uns, rd;
        logic [31:0] e_data;
        logic        e_we, e_mis, e_per;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        we, mis, to;
    } exp_t;

    exp_t sb[$];

    function automatic vec_t mk(logic [31:0] npc, wd, alu, logic [1:0] wsel, width,
                                logic dst, rnd, mwe, rwe, uns, rd,
                                logic [31:0] e_data, logic e_we, e_mis, e_per);
        vec_t v;
        v.npc = npc; v.wd = wd; v.alu = alu; v.wsel = wsel; v.width = width;
        v.dst = dst; v.rnd = rnd; v.mwe = mwe; v.rwe = rwe; v.uns = uns; v.rd = rd;
        v.e_data = e_data; v.e_we = e_we; v.e_mis = e_mis; v.e_per = e_per;
        return v;
    endfunction

    function automatic exp_t mke(logic [31:0] d, logic we, mis, to);
        exp_t e;
        e.data = d; e.we = we; e.mis = mis; e.to = to;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic drive(vec_t v);
        next_pc_mem = v.npc; write_data_mem = v.wd; alu_result_mem = v.alu;
        wb_sel_mem = v.wsel; read_width_mem = v.width; wrt_dst_mem = v.dst;
        random_mem = v.rnd; mem_wrt_en_mem = v.mwe; reg_wrt_en_mem = v.rwe;
        read_unsigned_mem = v.uns; rd_en_mem = v.rd;
    endtask

    task automatic pop_check(string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (e.we || e.to) chk({name, "_wb_data"}, wb_data_wb, e.data);
            chk({name, "_reg_we"}, {31'd0, reg_wrt_en_wb}, {31'd0, e.we});
            chk({name, "_misalign"}, {31'd0, misalign_err_wb}, {31'd0, e.mis});
            chk({name, "_timeout"}, {31'd0, timeout_err_wb}, {31'd0, e.to});
            $display("txn %s: wb_data=%h reg_we=%b mis=%b to=%b", name, wb_data_wb,
                     reg_wrt_en_wb, misalign_err_wb, timeout_err_wb);
        end
    endtask

    // Runs one instruction until the stage releases, then checks MEM/WB.
    task automatic run_op(string name, vec_t v, int delay, logic [31:0] rdata, exp_t e,
                          output int stalls, output int reqs, output logic we_c,
                          output logic [31:0] addr_c, output logic [3:0] be_c,
                          output logic [31:0] wd_c);
        logic s;
        stalls = 0; reqs = 0; we_c = 1'b0; addr_c = 32'h0; be_c = 4'h0; wd_c = 32'h0;
        @(posedge clk);
        #1;
        ack_cfg = delay;
        dmem_rdata = rdata;
        drive(v);
        sb.push_back(e);
        #2;
        chk({name, "_req_first_cycle"}, {31'd0, dmem_req}, 32'd0);
        s = stall_mem;
        while (s && stalls < 400) begin
            stalls++;
            @(posedge clk);
            #3;
            s = stall_mem;
            if (dmem_req) begin
                reqs++;
                we_c = dmem_we; addr_c = dmem_addr; be_c = dmem_be; wd_c = dmem_wdata;
            end
        end
        if (s) chk({name, "_stall_bound"}, 32'd1, 32'd0);
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        pop_check(name);
    endtask

    localparam int NV = 13;
    vec_t tab[NV];

    initial begin
        int          st, rq;
        logic        wc;
        logic [31:0] ac, wdc;
        logic [3:0]  bc;
        vec_t        nop;

        n_cmp = 0; n_err = 0; ack_cfg = -1; stray_ack = 1'b0; dmem_rdata = 32'h0;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        //            npc          wd            alu          ws wd dst rnd mwe rwe uns rd  e_data        we mis per
        tab[0]  = mk(32'h0,       32'h0,        32'h1234,    0, 2, 0, 0, 0, 1, 0, 0, 32'h1234,      1, 0, 0);
        tab[1]  = mk(32'h100,     32'h0,        32'h40,      2, 2, 0, 0, 0, 1, 0, 0, 32'h100,       1, 0, 0);
        tab[2]  = mk(32'h0,       32'h0,        32'h55,      0, 2, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0);
        tab[3]  = mk(32'h0,       32'h0,        32'h101,     1, 2, 0, 0, 0, 1, 0, 1, 32'h0,         0, 1, 0);
        tab[4]  = mk(32'h0,       32'h0,        32'h103,     1, 1, 0, 0, 0, 1, 0, 1, 32'h0,         0, 1, 0);
        tab[5]  = mk(32'h0,       32'h1111,     32'h202,     0, 2, 0, 0, 1, 0, 0, 0, 32'h0,         0, 1, 0);
        tab[6]  = mk(32'h0,       32'hCAFE_F00D, 32'h8000,   0, 2, 1, 0, 1, 0, 0, 0, 32'h0,         0, 0, 1);
        tab[7]  = mk(32'h0,       32'h0,        32'h0,       3, 2, 0, 1, 0, 1, 0, 0, 32'hACE1_0001, 1, 0, 0);
        tab[8]  = mk(32'h0,       32'h0,        32'h0,       3, 2, 0, 1, 0, 1, 0, 0, 32'hD650_8003, 1, 0, 0);
        tab[9]  = mk(32'h0,       32'h0,        32'h0,       3, 2, 0, 1, 0, 1, 0, 0, 32'hEB08_4002, 1, 0, 0);
        tab[10] = mk(32'h0,       32'h0,        32'h0,       3, 2, 0, 0, 0, 1, 0, 0, 32'h7584_2001, 1, 0, 0);
        tab[11] = mk(32'h0,       32'h0,        32'h0,       3, 2, 0, 0, 0, 1, 0, 0, 32'h7584_2001, 1, 0, 0);
        tab[12] = mk(32'h0,       32'h7777,     32'h9000,    1, 2, 1, 0, 1, 1, 0, 1, 32'h0,         0, 0, 1);

        drive(nop);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_stall", {31'd0, stall_mem}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wb_data", wb_data_wb, 32'd0);
        chk("rst_flags", {28'd0, reg_wrt_en_wb, misalign_err_wb, timeout_err_wb, periph_we}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tab[i]);
            sb.push_back(mke(tab[i].e_data, tab[i].e_we, tab[i].e_mis, 1'b0));
            #2;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_mem}, 32'd0);
            chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, 32'd0);
            chk($sformatf("v%0d_periph_we", i), {31'd0, periph_we}, {31'd0, tab[i].e_per});
            if (tab[i].e_per) chk($sformatf("v%0d_periph_wdata", i), periph_wdata, tab[i].wd);
            if (i > 0) pop_check($sformatf("v%0d", i - 1));
        end
        @(posedge clk);
        #1;
        drive(nop);
        #2;
        pop_check($sformatf("v%0d", NV - 1));

        run_op("lb", mk(0, 0, 32'h103, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 2, 32'h80FF_0000,
               mke(32'hFFFF_FF80, 1, 0, 0), st, rq, wc, ac, bc, wdc);
        chk("lb_stall_cycles", st, 4);
        chk("lb_req_cycles", rq, 3);
        chk("lb_addr", ac, 32'h100);
        chk("lb_we", {31'd0, wc}, 32'd0);

        run_op("lbu", mk(0, 0, 32'h103, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), 2, 32'h80FF_0000,
               mke(32'h0000_0080, 1, 0, 0), st, rq, wc, ac, bc, wdc);
        chk("lbu_stall_cycles", st, 4);

        run_op("sh", mk(0, 32'hDEAD_BEEF, 32'h202, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 0, 32'h0,
               mke(32'h0, 0, 0, 0), st, rq, wc, ac, bc, wdc);
        chk("sh_stall_cycles", st, 2);
        chk("sh_req_cycles", rq, 1);
        chk("sh_we", {31'd0, wc}, 32'd1);
        chk("sh_be", {28'd0, bc}, 32'hC);
        chk("sh_wdata", wdc, 32'hBEEF_BEEF);
        chk("sh_addr", ac, 32'h200);

        run_op("sb", mk(0, 32'h0000_12A5, 32'h201, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, 32'h0,
               mke(32'h0, 0, 0, 0), st, rq, wc, ac, bc, wdc);
        chk("sb_be", {28'd0, bc}, 32'h2);
        chk("sb_wdata", wdc, 32'hA5A5_A5A5);

        run_op("lh", mk(0, 0, 32'h302, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1, 32'h8001_7FFF,
               mke(32'hFFFF_8001, 1, 0, 0), st, rq, wc, ac, bc, wdc);
        run_op("lhu", mk(0, 0, 32'h300, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0), 1, 32'h8001_7FFF,
               mke(32'h0000_7FFF, 1, 0, 0), st, rq, wc, ac, bc, wdc);
        run_op("lw", mk(0, 0, 32'h300, 1, 2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1, 32'h1234_5678,
               mke(32'h1234_5678, 1, 0, 0), st, rq, wc, ac, bc, wdc);
        chk("lw_addr", ac, 32'h300);
        chk("lw_be", {28'd0, bc}, 32'hF);

        run_op("rng_stalled", mk(0, 0, 32'h400, 3, 2, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0), 3, 32'h0,
               mke(32'h7584_2001, 1, 0, 0), st, rq, wc, ac, bc, wdc);
        run_op("rng_after", mk(0, 0, 0, 3, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 32'h0,
               mke(32'hBAE2_1003, 1, 0, 0), st, rq, wc, ac, bc, wdc);

        run_op("timeout", mk(0, 0, 32'h600, 1, 2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), -1, 32'h0,
               mke(32'h0, 0, 0, 1), st, rq, wc, ac, bc, wdc);
        chk("timeout_req_cycles", rq, 255);
        chk("timeout_stall_cycles", st, 256);

        // Reset in the middle of an access, followed by a stray ack.
        ack_cfg = -1;
        @(posedge clk);
        #1;
        drive(mk(0, 0, 32'h500, 1, 2, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #3;
        chk("rstbusy_req_before", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        drive(nop);
        @(posedge clk);
        #3;
        chk("rstbusy_req_after", {31'd0, dmem_req}, 32'd0);
        chk("rstbusy_stall_after", {31'd0, stall_mem}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #3;
            chk($sformatf("stray_req_%0d", k), {31'd0, dmem_req}, 32'd0);
            chk($sformatf("stray_wb_%0d", k), {30'd0, reg_wrt_en_wb, timeout_err_wb}, 32'd0);
        end
        run_op("rng_reseed", mk(0, 0, 0, 3, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 0, 32'h0,
               mke(32'hACE1_0001, 1, 0, 0), st, rq, wc, ac, bc, wdc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
